// File: rtl/cache_stats_readout_sequencer.sv
// rtl/cache_stats_readout_sequencer.sv - drains performance counters into a valid/ready word stream
//
// Purpose: on a start pulse, freezes the performance counters and walks select
// codes 0..N_CODES-1 on comm_o. Each returned word on comm_i is pushed into an
// output FIFO.
//
// Ports:
//   clock_i, resetn_i  clock and asynchronous active-low reset
//   start_i            one-cycle readout request (dropped and flagged while busy)
//   count_en_i         host request to run the counters
//   comm_o / comm_i    command word to, and return word from, the performance controller
//   data_o, valid_o,   FIFO head, driven to the consumer
//   ready_i            consumer handshake
//   busy_o, done_o     readout in progress / one-cycle completion pulse
//   overflow_o         sticky flag: start request seen while busy
module cache_stats_readout_sequencer #(
  parameter int N_CODES    = 20,
  parameter int SETTLE     = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock_i,
  input  logic        resetn_i,
  input  logic        start_i,
  input  logic        count_en_i,
  output logic [31:0] comm_o,
  input  logic [31:0] comm_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [4:0]    code_q, code_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [4:0]    sel_q, sel_d;
  logic          cen_q, cen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          start_q, start_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [31:0]   mem [FIFO_DEPTH];

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  // Full when pointers differ only in the wrap bit.
  assign fifo_full  = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
  assign fifo_empty = (wptr_q == rptr_q);
  assign pop        = !fifo_empty && ready_i;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    push    = 1'b0;
    // busy_q stays high through DONE, so a start in that cycle is also dropped.
    start_d = start_i && !busy_q && !start_q && (state_q == S_IDLE);
    ovf_d   = ovf_q | (start_i && busy_q);

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_ISSUE;
          busy_d  = 1'b1;
          code_d  = 5'd0;
          sel_d   = 5'd0;
        end
      end
      S_ISSUE: begin
        sel_d   = code_q;
        cnt_d   = 8'(SETTLE - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A pop on the same edge frees a slot, so a full FIFO can still accept.
        // Otherwise hold: comm_o is unchanged, so comm_i stays valid.
        if (!fifo_full || pop) begin
          push = 1'b1;
          if (code_q == 5'(N_CODES - 1)) begin
            state_d = S_DONE;
          end else begin
            code_d  = code_q + 5'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        sel_d   = 5'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Freeze on the edge busy rises; resume only one cycle after busy falls,
    // so the whole readout sees frozen counters.
    cen_d  = count_en_i && !busy_d && !busy_q;
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= S_IDLE;
      code_q  <= 5'd0;
      cnt_q   <= 8'd0;
      sel_q   <= 5'd0;
      cen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      start_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      start_q <= start_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock_i) begin
    if (push) mem[wptr_q[AW-1:0]] <= comm_i;
  end

  assign comm_o     = {7'd0, cen_q, 19'd0, sel_q};
  assign valid_o    = !fifo_empty;
  assign data_o     = fifo_empty ? 32'd0 : mem[rptr_q[AW-1:0]];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_cache_stats_readout_sequencer.sv
// tb/tb_cache_stats_readout_sequencer.sv - self-checking bench for cache_stats_readout_sequencer
module tb_cache_stats_readout_sequencer;
  localparam int N = 20;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        count_en = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] comm_o;
  logic [31:0] comm_i = 32'd0;
  logic [31:0] data_o;
  logic        valid, busy, done, ovf;

  logic [31:0] tab [32];
  logic [31:0] got [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Performance controller: registers the addressed counter word one edge after comm_o.
  always @(posedge clk) comm_i <= tab[comm_o[4:0]];

  // Consumer: words handed over on the coming edge (inputs are stable at the negedge).
  always @(negedge clk) if (rstn && valid && ready) got.push_back(data_o);

  cache_stats_readout_sequencer #(.N_CODES(N), .SETTLE(2), .FIFO_DEPTH(16)) dut (
    .clock_i(clk), .resetn_i(rstn), .start_i(start), .count_en_i(count_en),
    .comm_o(comm_o), .comm_i(comm_i), .data_o(data_o), .valid_o(valid),
    .ready_i(ready), .busy_o(busy), .done_o(done), .overflow_o(ovf)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) tab[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    tab[14] = 32'd0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int at;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        at = i;
        break;
      end
      step();
    end
    chk({tag, "_done_seen"}, 32'(at >= 0), 32'd1);
  endtask

  // Expected stream: one word per code, in code order, exactly N words.
  task automatic check_stream(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(N));
    for (int i = 0; i < N; i++)
      if (i < got.size()) chk($sformatf("%s_w%0d", tag, i), got[i], tab[i]);
  endtask

  initial begin
    int t0, first_v, done_at, c24bad;

    // Reset state
    for (int i = 0; i < 32; i++) tab[i] = 32'd0;
    repeat (3) step();
    chk("rst_comm", comm_o, 32'd0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rstn = 1'b1;
    step();

    // Basic readout, code*0x1111 returns, consumer always ready
    for (int i = 0; i < 32; i++) tab[i] = i * 32'h1111;
    got.delete();
    ready = 1'b1;
    pulse_start();
    t0 = cyc;
    step();
    chk("basic_busy_rise", busy, 1'b1);
    chk("basic_code0", comm_o[4:0], 5'd0);
    first_v = -1;
    done_at = -1;
    c24bad  = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy && comm_o[24]) c24bad++;
      if (valid && first_v < 0) first_v = cyc - t0;
      if (done) begin
        done_at = cyc - t0;
        break;
      end
      step();
    end
    chk("basic_first_valid_edge", 32'(first_v), 32'd4);
    chk("basic_done_edge", 32'(done_at), 32'(3 * N + 2));
    chk("basic_cen_during_busy", 32'(c24bad), 32'd0);
    step();
    chk("basic_done_pulse", done, 1'b0);
    chk("basic_busy_fall", busy, 1'b0);
    repeat (4) step();
    check_stream("basic");

    // Count gating
    count_en = 1'b1;
    fill_random();
    got.delete();
    step();
    chk("gate_idle_cen", comm_o[24], 1'b1);
    pulse_start();
    step();
    chk("gate_cen_drop", comm_o[24], 1'b0);
    wait_done("gate", 200);
    chk("gate_cen_at_done", comm_o[24], 1'b0);
    step();
    chk("gate_cen_back", comm_o[24], 1'b1);
    repeat (4) step();
    check_stream("gate");
    count_en = 1'b0;

    // Backpressure and full boundary
    fill_random();
    got.delete();
    ready = 1'b0;
    pulse_start();
    repeat (80) step();
    chk("bp_busy", busy, 1'b1);
    chk("bp_stall_code", comm_o[4:0], 5'd16);
    chk("bp_valid", valid, 1'b1);
    chk("bp_head", data_o, tab[0]);
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    chk("full_pop_push_same_edge", comm_o[4:0], 5'd17);
    chk("full_new_head", data_o, tab[1]);
    repeat (10) step();
    chk("full_restall_code", comm_o[4:0], 5'd17);
    ready = 1'b1;
    wait_done("bp", 300);
    repeat (20) step();
    check_stream("bp");
    chk("bp_no_ovf", ovf, 1'b0);

    // Overflow, with random consumer readiness
    fill_random();
    got.delete();
    pulse_start();
    repeat (4) step();
    pulse_start();
    chk("ovf_set", ovf, 1'b1);
    done_at = -1;
    for (int i = 0; i < 600; i++) begin
      if (done) begin
        done_at = i;
        break;
      end
      ready = 1'($urandom_range(0, 1));
      step();
    end
    chk("ovf_done_seen", 32'(done_at >= 0), 32'd1);
    ready = 1'b1;
    repeat (20) step();
    check_stream("ovf");
    chk("ovf_sticky", ovf, 1'b1);

    // Asynchronous reset in the middle of a readout
    fill_random();
    got.delete();
    ready = 1'b0;
    pulse_start();
    repeat (5) step();
    chk("arst_pre_valid", valid, 1'b1);
    chk("arst_pre_busy", busy, 1'b1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_valid", valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_comm", comm_o, 32'd0);
    chk("arst_ovf", ovf, 1'b0);
    step();
    rstn = 1'b1;
    step();
    ready = 1'b1;
    got.delete();
    pulse_start();
    wait_done("arst", 200);
    repeat (4) step();
    check_stream("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_stats_readout_sequencer.md
# cache_stats_readout_sequencer

Drains the L2 performance controller's statistics counters into a host-readable stream. The sequencer sits directly upstream of the performance controller's `comm_i` configuration port and downstream of its `comm_o` return port. On a start request it freezes counting, walks the counter select codes, and captures each returned 32-bit word. Captured words are pushed into a small FIFO drained by a valid/ready consumer (host/UART bridge).

## Interface
- `N_CODES`, 20: number of select codes walked, 0..N_CODES-1, max 32.
- `SETTLE`, 2: cycles from driving a select code to sampling the return word, min 2.
- `FIFO_DEPTH`, 16: output FIFO entries, power of two, min 2.

- `clock_i` in 1: single clock, all logic on its rising edge.
- `resetn_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse. Begins a readout; ignored while `busy_o`=1.
- `count_en_i` in 1: host request to run the counters.
- `comm_o` out 32: to performance controller. Bit 24 = count enable; bits 4:0 = select code; all other bits 0.
- `comm_i` in 32: return word from the performance controller.
- `data_o` out 32: FIFO head word.
- `valid_o` out 1: FIFO non-empty.
- `ready_i` in 1: consumer accepts `data_o` when `valid_o && ready_i`.
- `busy_o` out 1: readout in progress.
- `done_o` out 1: one-cycle pulse after the last word is pushed.
- `overflow_o` out 1: sticky. Set on a start request while busy; cleared by reset only.

## Operation
- **Reset values:** all outputs 0, state IDLE, FIFO empty, code counter 0.
- **Count enable:** `comm_o[24]` = `count_en_i && !busy_o`, registered. Counters freeze for the whole readout, so the snapshot is consistent.
- **State machine:**
  - IDLE: on `start_i` → ISSUE, `busy_o`=1, code=0.
  - ISSUE: drive `comm_o[4:0]`=code, load wait counter = SETTLE-1 → WAIT.
  - WAIT: decrement; at 0 → CAPTURE.
  - CAPTURE: if the FIFO is not full, push `comm_i`.
    - If code==N_CODES-1 → DONE.
    - Otherwise code+1 → ISSUE.
    - If the FIFO is full, stay in CAPTURE, keep the same code, and re-sample each cycle until space exists. Because `comm_o` is held, the sampled word stays valid.
  - DONE: pulse `done_o`, `busy_o`=0, `comm_o[4:0]`=0 → IDLE.
- **Word ordering:** each 64-bit counter appears in the stream as low word then high word. Unused codes (e.g. 5'b01110) return 0 and are pushed as 0. The stream length is exactly N_CODES words.
- **FIFO:** circular buffer with read/write pointers one bit wider than log2(FIFO_DEPTH).
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - Simultaneous push and pop while full: the pop frees space, and the push is accepted the same cycle.
  - Push and pop while empty: the push is stored, and `valid_o` rises next cycle.
- **Overflow:** `start_i` while busy is dropped and sets `overflow_o`. `start_i` in the same cycle as the DONE state is also treated as busy and dropped.
- **Reset mid-readout:** returns immediately to the reset values. FIFO contents are discarded and `comm_o` goes to 0, so the counters stop.

## Timing
- `start_i` sampled at edge 0 → `busy_o`=1 and code 0 driven after edge 1.
- With SETTLE=2 and no backpressure, one word is pushed every SETTLE+1 = 3 cycles.
  - First push occurs at edge 4.
  - `valid_o` is high after edge 4.
  - `done_o` pulses 3·N_CODES+2 edges after start, i.e. edge 62 for N_CODES=20.
- The performance controller registers its return word one edge after `comm_o` changes. SETTLE < 2 is illegal.
- `data_o`/`valid_o` come combinationally from FIFO storage and pointers.
- A pop takes effect at the edge where `valid_o && ready_i`.

## Test plan
- **Basic readout:** model returns code·0x1111 for each code; `ready_i`=1, start pulse. Required:
  - 20 words 0x0, 0x1111, …, 0x14443 in order;
  - `done_o` at edge 62;
  - `comm_o[24]`=0 throughout `busy_o`.
- **Backpressure:** `ready_i`=0 for the whole readout, FIFO_DEPTH=16. Required:
  - stall in CAPTURE with code 16 held on `comm_o`;
  - after `ready_i`=1, all 20 words arrive in order, none duplicated or lost.
- **Full boundary:** FIFO full and in CAPTURE; assert `ready_i` for exactly one cycle. Required: one pop and one push on the same edge; occupancy stays 16.
- **Overflow:** second `start_i` 5 cycles into a readout. Required:
  - `overflow_o`=1 and stays 1;
  - the stream still contains exactly 20 words.
- **Async reset:** deassert `resetn_i` mid-WAIT, off a clock edge. Required:
  - `valid_o`, `busy_o`, `comm_o` = 0 immediately;
  - after release, a new start yields a full 20-word stream starting at code 0.
- **Count gating:** `count_en_i`=1. Required:
  - `comm_o[24]`=1 while idle;
  - `comm_o[24]` drops the cycle after start;
  - `comm_o[24]` returns to 1 the cycle after `done_o`.
